button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/debounce_pkg.sv | 15 +
 rtl/debounce_channel.sv | 91 +++++++++
 rtl/button_debouncer.sv | 42 ++++
 tb/tb_button_debouncer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and constants for the button debouncer.
package debounce_pkg;

  // Per-channel debounce FSM states
  typedef enum logic [1:0] {
    STABLE_LOW   = 2'd0,
    CONFIRM_HIGH = 2'd1,
    STABLE_HIGH  = 2'd2,
    CONFIRM_LOW  = 2'd3
  } debounce_state_t;

  // Smallest stable_cycles that still leaves a confirm phase of at least one cycle
  localparam int unsigned MIN_STABLE_CYCLES = 2;

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debouncer: four-state FSM plus a sample counter.
// A level change is accepted only after stable_cycles identical consecutive samples.
//
// state        | meaning
// STABLE_LOW   | accepted level 0, counter idle at 0
// CONFIRM_HIGH | input seen high, counting consecutive high samples
// STABLE_HIGH  | accepted level 1, counter idle at 0
// CONFIRM_LOW  | input seen low, counting consecutive low samples
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned stable_cycles = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  output logic debounced,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CW = $clog2(stable_cycles + 1);
  localparam logic [CW-1:0] TERMINAL = CW'(stable_cycles);

  debounce_state_t state, state_nxt;
  logic [CW-1:0]   count, count_nxt, count_inc;
  logic            confirm_done;
  logic            debounced_nxt, rise_nxt, fall_nxt;

  // count never exceeds stable_cycles-1, so the increment cannot wrap
  assign count_inc    = count + CW'(1);
  assign confirm_done = (count_inc == TERMINAL);

  // State, counter and registered outputs, all updated on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STABLE_LOW;
      count      <= '0;
      debounced  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      debounced  <= debounced_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
    end
  end

  // Next-state and counter decode; counter falls back to 0 unless still confirming
  always_comb begin
    state_nxt = state;
    count_nxt = '0;
    unique case (state)
      STABLE_LOW: begin
        if (sample) begin
          state_nxt = CONFIRM_HIGH;
          count_nxt = CW'(1);
        end
      end
      CONFIRM_HIGH: begin
        if (!sample)           state_nxt = STABLE_LOW;
        else if (confirm_done) state_nxt = STABLE_HIGH;
        else                   count_nxt = count_inc;
      end
      STABLE_HIGH: begin
        if (!sample) begin
          state_nxt = CONFIRM_LOW;
          count_nxt = CW'(1);
        end
      end
      CONFIRM_LOW: begin
        if (sample)            state_nxt = STABLE_HIGH;
        else if (confirm_done) state_nxt = STABLE_LOW;
        else                   count_nxt = count_inc;
      end
      default: state_nxt = STABLE_LOW;
    endcase
  end

  // Output decode: a pulse fires exactly on the edge that completes a confirmation
  always_comb begin
    rise_nxt      = (state == CONFIRM_HIGH) && sample && confirm_done;
    fall_nxt      = (state == CONFIRM_LOW) && !sample && confirm_done;
    debounced_nxt = debounced;
    if (rise_nxt)      debounced_nxt = 1'b1;
    else if (fall_nxt) debounced_nxt = 1'b0;
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button debouncer: one independent debounce_channel per input bit,
// with a combined change strobe across all channels.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned bits          = 1,
  parameter int unsigned stable_cycles = 50000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [bits-1:0] sync_in,
  output logic [bits-1:0] debounced,
  output logic [bits-1:0] rise_pulse,
  output logic [bits-1:0] fall_pulse,
  output logic            any_change
);

  // Reject configurations without a real confirm window
  if (stable_cycles < MIN_STABLE_CYCLES) begin : g_bad_cfg
    $error("button_debouncer: stable_cycles must be at least %0d", MIN_STABLE_CYCLES);
  end

  // One independent channel per input bit
  for (genvar i = 0; i < int'(bits); i++) begin : g_chan
    debounce_channel #(
      .stable_cycles(stable_cycles)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .sample    (sync_in[i]),
      .debounced (debounced[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  // Combined strobe straight from the registered pulses, no added latency
  always_comb begin
    any_change = |{rise_pulse, fall_pulse};
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with bits=2, stable_cycles=4.
module tb_button_debouncer;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sync_in;
  logic [1:0] debounced, rise_pulse, fall_pulse;
  logic       any_change;

  int errors = 0;
  int checks = 0;

  button_debouncer #(.bits(2), .stable_cycles(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .sync_in   (sync_in),
    .debounced (debounced),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] deb, input logic [1:0] rise,
                         input logic [1:0] fall, input logic any);
    chk({tag, ".debounced"}, debounced, deb);
    chk({tag, ".rise"}, rise_pulse, rise);
    chk({tag, ".fall"}, fall_pulse, fall);
    chk({tag, ".any"}, {1'b0, any_change}, {1'b0, any});
  endtask

  initial begin
    // Reset state
    reset   = 1'b1;
    sync_in = 2'b00;
    #1;
    chk_all("reset_async", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    tick();
    chk_all("reset_held", 2'b00, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    tick();
    tick();
    chk_all("idle_low", 2'b00, 2'b00, 2'b00, 1'b0);

    // Channel 0 held high: accepted after the 4th sample only
    sync_in = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("rise0_wait%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("rise0_edge4", 2'b01, 2'b01, 2'b00, 1'b1);
    tick();
    chk_all("rise0_after", 2'b01, 2'b00, 2'b00, 1'b0);

    // Channel 1 joins: only channel 1 pulses
    sync_in = 2'b11;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("rise1_wait%0d", i), 2'b01, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("rise1_edge4", 2'b11, 2'b10, 2'b00, 1'b1);
    tick();
    chk_all("rise1_after", 2'b11, 2'b00, 2'b00, 1'b0);

    // Both channels fall together
    sync_in = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("fall_wait%0d", i), 2'b11, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("fall_edge4", 2'b00, 2'b00, 2'b11, 1'b1);
    tick();
    chk_all("fall_after", 2'b00, 2'b00, 2'b00, 1'b0);

    // 3-cycle glitch on channel 0 is rejected
    sync_in = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("glitch_hi%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    sync_in = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk_all($sformatf("glitch_lo%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    // Back in STABLE_LOW: a fresh press needs the full 4 samples again
    sync_in = 2'b01;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("repress_wait%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("repress_edge4", 2'b01, 2'b01, 2'b00, 1'b1);
    sync_in = 2'b00;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("release_wait%0d", i), 2'b01, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("release_edge4", 2'b00, 2'b00, 2'b01, 1'b1);

    // Channel 1 toggling every cycle never settles
    for (int i = 0; i < 40; i++) begin
      sync_in = {~i[0], 1'b0};
      tick();
      chk_all($sformatf("toggle%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    sync_in = 2'b00;
    tick();

    // Reset mid-confirm aborts; input held through release needs a full window
    sync_in = 2'b01;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk_all("midconfirm_rst", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    tick();
    chk_all("midconfirm_rst_held", 2'b00, 2'b00, 2'b00, 1'b0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("postrst_wait%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("postrst_edge4", 2'b01, 2'b01, 2'b00, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk_all($sformatf("postrst_once%0d", i), 2'b01, 2'b00, 2'b00, 1'b0);
    end

    // Async reset clears an accepted level without waiting for a clock edge
    sync_in = 2'b10;
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_clear", 2'b00, 2'b00, 2'b00, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk_all($sformatf("held_wait%0d", i), 2'b00, 2'b00, 2'b00, 1'b0);
    end
    tick();
    chk_all("held_edge4", 2'b10, 2'b10, 2'b00, 1'b1);
    tick();
    chk_all("held_after", 2'b10, 2'b00, 2'b00, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
